// File: rtl/bp_me_stream_mem_responder.sv
// BedRock stream memory responder backed by a register array; multi-beat reads return critical word first.
// Define BP_ME_STREAM_MEM_RESPONDER_CHECK_EN to enable simulation-only protocol assertions.
module bp_me_stream_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int l2_fill_width_p = 64,
    parameter int payload_width_p = 16,
    parameter int mem_els_p       = 256,
    parameter int latency_p       = 2,
    // header layout, LSB first: msg_type[3:0], addr, size[2:0], payload
    localparam int mem_header_width_lp = 4 + paddr_width_p + 3 + payload_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [mem_header_width_lp-1:0] mem_cmd_header_i,
    input  logic [l2_fill_width_p-1:0]     mem_cmd_data_i,
    input  logic                           mem_cmd_v_i,
    output logic                           mem_cmd_ready_and_o,
    input  logic                           mem_cmd_last_i,
    output logic [mem_header_width_lp-1:0] mem_resp_header_o,
    output logic [l2_fill_width_p-1:0]     mem_resp_data_o,
    output logic                           mem_resp_v_o,
    input  logic                           mem_resp_ready_and_i,
    output logic                           mem_resp_last_o
);
    localparam int bpb_lp       = l2_fill_width_p / 8;
    localparam int lg_bpb_lp    = $clog2(bpb_lp);
    localparam int lg_els_lp    = $clog2(mem_els_p);
    localparam int max_beats_lp = (1024 / l2_fill_width_p > 1) ? 1024 / l2_fill_width_p : 1;
    localparam int kw_lp        = $clog2(max_beats_lp) + 1;
    localparam int cw_lp        = $clog2(latency_p + 1) + 1;
    localparam logic [cw_lp-1:0] lat_init_lp = cw_lp'((latency_p > 0) ? latency_p - 1 : 0);

    localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
    localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
    localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

    typedef logic [mem_header_width_lp-1:0] hdr_t;
    typedef enum logic [2:0] {e_ready, e_write, e_wait, e_wait_ack, e_read, e_ack} state_e;

    function automatic logic [2:0] size_f(input hdr_t h);
        return h[4+paddr_width_p +: 3];
    endfunction

    function automatic logic [kw_lp-1:0] last_k_f(input hdr_t h);
        int sz;
        sz = int'(size_f(h));
        return (sz > lg_bpb_lp) ? kw_lp'((1 << (sz - lg_bpb_lp)) - 1) : '0;
    endfunction

    // Beat k of a message: index wraps inside its N-word aligned block.
    function automatic logic [lg_els_lp-1:0] beat_idx_f(input hdr_t h, input logic [kw_lp-1:0] k);
        logic [lg_els_lp-1:0] w, m;
        w = h[4+lg_bpb_lp +: lg_els_lp];
        m = lg_els_lp'(last_k_f(h));
        return (w & ~m) | ((w + lg_els_lp'(k)) & m);
    endfunction

    function automatic logic is_rd_f(input hdr_t h);
        return (h[3:0] == e_bedrock_mem_rd) || (h[3:0] == e_bedrock_mem_uc_rd);
    endfunction

    function automatic logic is_wr_f(input hdr_t h);
        return (h[3:0] == e_bedrock_mem_wr) || (h[3:0] == e_bedrock_mem_uc_wr);
    endfunction

    state_e               state_q, state_d;
    hdr_t                 hdr_q, hdr_d;
    logic [kw_lp-1:0]     k_q, k_d;
    logic [cw_lp-1:0]     cnt_q, cnt_d;
    logic                 store_q, store_d;
    logic                 cmd_ready, resp_v, resp_last, cmd_fire, we;
    hdr_t                 cur_hdr;
    logic [kw_lp-1:0]     cur_k;
    logic [lg_els_lp-1:0] wr_idx, rd_idx;
    logic [bpb_lp-1:0]    wmask;
    logic [31:0]          woff, wlen;
    logic                 wfull;
    logic [l2_fill_width_p-1:0] wword, rdata_q;
    logic [l2_fill_width_p-1:0] mem_q [mem_els_p];

    assign cmd_fire = mem_cmd_v_i & mem_cmd_ready_and_o;
    assign cur_hdr  = (state_q == e_ready) ? mem_cmd_header_i : hdr_q;
    assign cur_k    = (state_q == e_ready) ? '0 : k_q;
    assign we       = cmd_fire & ((state_q == e_ready) ? is_wr_f(mem_cmd_header_i) : store_q);
    assign wr_idx   = beat_idx_f(cur_hdr, cur_k);
    assign rd_idx   = beat_idx_f(hdr_d, k_d);
    assign wfull    = int'(size_f(cur_hdr)) >= lg_bpb_lp;
    assign wlen     = 32'(1) << size_f(cur_hdr);
    assign woff     = 32'(cur_hdr[4 +: lg_bpb_lp]);

    for (genvar gi = 0; gi < bpb_lp; gi++) begin : g_byte
        assign wmask[gi] = wfull | ((32'(gi) >= woff) && (32'(gi) < woff + wlen));
        assign wword[gi*8 +: 8] = wmask[gi] ? mem_cmd_data_i[gi*8 +: 8] : mem_q[wr_idx][gi*8 +: 8];
    end

    // Read port looks one cycle ahead so the beat is ready when e_read is entered.
    always_ff @(posedge clk_i) begin
        if (we)
            mem_q[wr_idx] <= wword;
        rdata_q <= mem_q[rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        store_d   = store_q;
        cmd_ready = 1'b0;
        resp_v    = 1'b0;
        resp_last = 1'b0;
        case (state_q)
            e_ready: begin
                cmd_ready = 1'b1;
                if (mem_cmd_v_i) begin
                    hdr_d = mem_cmd_header_i;
                    cnt_d = lat_init_lp;
                    if (is_rd_f(mem_cmd_header_i)) begin
                        k_d     = '0;
                        state_d = (latency_p == 0) ? e_read : e_wait;
                    end else begin
                        k_d     = kw_lp'(1);
                        store_d = is_wr_f(mem_cmd_header_i);
                        if (mem_cmd_last_i)
                            state_d = (latency_p == 0) ? e_ack : e_wait_ack;
                        else
                            state_d = e_write;
                    end
                end
            end
            e_write: begin
                cmd_ready = 1'b1;
                if (mem_cmd_v_i) begin
                    k_d = k_q + kw_lp'(1);
                    if (mem_cmd_last_i) begin
                        cnt_d   = lat_init_lp;
                        state_d = (latency_p == 0) ? e_ack : e_wait_ack;
                    end
                end
            end
            e_wait, e_wait_ack: begin
                if (cnt_q == '0)
                    state_d = (state_q == e_wait) ? e_read : e_ack;
                else
                    cnt_d = cnt_q - cw_lp'(1);
            end
            e_read: begin
                resp_v    = 1'b1;
                resp_last = (k_q == last_k_f(hdr_q));
                if (mem_resp_ready_and_i) begin
                    if (resp_last) begin
                        k_d     = '0;
                        state_d = e_ready;
                    end else begin
                        k_d = k_q + kw_lp'(1);
                    end
                end
            end
            e_ack: begin
                resp_v    = 1'b1;
                resp_last = 1'b1;
                if (mem_resp_ready_and_i)
                    state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase
    end

    assign mem_cmd_ready_and_o = cmd_ready & ~reset_i;
    assign mem_resp_v_o        = resp_v & ~reset_i;
    assign mem_resp_last_o     = resp_last & ~reset_i;
    assign mem_resp_header_o   = hdr_q;
    assign mem_resp_data_o     = (state_q == e_read) ? rdata_q : '0;

`ifdef BP_ME_STREAM_MEM_RESPONDER_CHECK_EN
    logic                       stall_q;
    hdr_t                       stall_hdr_q;
    logic [l2_fill_width_p-1:0] stall_data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= 1'b0;
        end else begin
            stall_q      <= mem_resp_v_o & ~mem_resp_ready_and_i;
            stall_hdr_q  <= mem_resp_header_o;
            stall_data_q <= mem_resp_data_o;
            if (stall_q)
                assert (mem_resp_v_o && mem_resp_header_o == stall_hdr_q && mem_resp_data_o == stall_data_q)
                else $error("resp beat dropped or changed before transfer");
            if (cmd_fire) begin
                assert (mem_cmd_last_i == (cur_k == last_k_f(cur_hdr)))
                else $error("cmd last on wrong beat for size");
                if (state_q == e_write)
                    assert (mem_cmd_header_i == hdr_q)
                    else $error("cmd last missing before next header");
                if (state_q == e_ready)
                    assert ((mem_cmd_header_i[4 +: paddr_width_p] >> lg_bpb_lp) < paddr_width_p'(mem_els_p))
                    else $error("cmd addr index beyond array depth");
            end
        end
    end
`endif
endmodule

// File: tb/tb_bp_me_stream_mem_responder.sv
// Scoreboard bench for bp_me_stream_mem_responder: byte-level memory model, random backpressure.
module tb_bp_me_stream_mem_responder;
    localparam int PADDR = 40, W = 64, PAY = 16, ELS = 256, LAT = 2;
    localparam int H = 4 + PADDR + 3 + PAY;
    localparam logic [3:0] RD = 4'd0, WR = 4'd1, UC_RD = 4'd2, UC_WR = 4'd3, PRE = 4'd4;

    logic         clk = 1'b0;
    logic         rst;
    logic [H-1:0] cmd_hdr, resp_hdr;
    logic [W-1:0] cmd_data, resp_data;
    logic         cmd_v, cmd_ready, cmd_last, resp_v, resp_ready, resp_last;

    bp_me_stream_mem_responder #(
        .paddr_width_p(PADDR), .l2_fill_width_p(W), .payload_width_p(PAY),
        .mem_els_p(ELS), .latency_p(LAT)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .mem_cmd_header_i(cmd_hdr), .mem_cmd_data_i(cmd_data), .mem_cmd_v_i(cmd_v),
        .mem_cmd_ready_and_o(cmd_ready), .mem_cmd_last_i(cmd_last),
        .mem_resp_header_o(resp_hdr), .mem_resp_data_o(resp_data), .mem_resp_v_o(resp_v),
        .mem_resp_ready_and_i(resp_ready), .mem_resp_last_o(resp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [H-1:0] hdr;
        logic [W-1:0] data;
        logic         last;
        int           cyc;   // expected cycle of first appearance, -1 = unchecked
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] mm [ELS*8];
    int         total = 0, bad = 0, cyc = 0;
    bit         rand_rdy = 0, lat_done = 0, prev_stall = 0;
    logic [H-1:0] prev_hdr;
    logic [W-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 resp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [H-1:0] mk_hdr(input logic [3:0] m, input int a, input int s);
        logic [PAY-1:0] p;
        p = PAY'($urandom);
        return {p, 3'(s), PADDR'(a), m};
    endfunction

    function automatic int nbeats(input int s);
        return ((1 << s) > W/8) ? (1 << s) / (W/8) : 1;
    endfunction

    function automatic int word_of(input int a, input int s, input int k);
        int w, n;
        w = (a / (W/8)) % ELS;
        n = nbeats(s);
        return (w - (w % n)) + ((w % n + k) % n);
    endfunction

    function automatic logic [W-1:0] rd_word(input int idx);
        logic [W-1:0] r;
        for (int b = 0; b < W/8; b++) r[b*8 +: 8] = mm[idx*(W/8) + b];
        return r;
    endfunction

    task automatic send(input logic [H-1:0] h, input logic [W-1:0] d [16], input int n, output int hcyc);
        int t;
        hcyc = -1;
        for (int k = 0; k < n; k++) begin
            cmd_v = 1'b1; cmd_hdr = h; cmd_data = d[k]; cmd_last = (k == n - 1);
            t = 0;
            @(negedge clk);
            while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
            total++;
            if (!cmd_ready) begin
                bad++;
                $display("FAIL cmd_accept beat=%0d got ready=0 want ready=1", k);
            end
            if (k == 0) hcyc = cyc;
            @(posedge clk); #1;
        end
        cmd_v = 1'b0; cmd_last = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] m, input int a, input int s, input logic [W-1:0] d [16]);
        logic [H-1:0] h;
        int n, hc, off, w;
        exp_t x;
        h = mk_hdr(m, a, s);
        n = nbeats(s);
        send(h, d, n, hc);
        if (m == WR || m == UC_WR) begin
            if ((1 << s) >= W/8) begin
                for (int k = 0; k < n; k++)
                    for (int b = 0; b < W/8; b++) mm[word_of(a, s, k)*(W/8) + b] = d[k][b*8 +: 8];
            end else begin
                off = a % (W/8);
                w = (a / (W/8)) % ELS;
                for (int b = off; b < off + (1 << s); b++) mm[w*(W/8) + b] = d[0][b*8 +: 8];
            end
        end
        x.hdr = h; x.data = '0; x.last = 1'b1; x.cyc = -1;
        q.push_back(x);
    endtask

    task automatic do_read(input logic [3:0] m, input int a, input int s, input int nexp);
        logic [W-1:0] d [16];
        logic [H-1:0] h;
        int n, hc;
        exp_t x;
        for (int k = 0; k < 16; k++) d[k] = '0;
        h = mk_hdr(m, a, s);
        n = nbeats(s);
        send(h, d, 1, hc);
        for (int k = 0; k < n && k < nexp; k++) begin
            x.hdr = h; x.data = rd_word(word_of(a, s, k)); x.last = (k == n - 1);
            x.cyc = (k == 0) ? hc + LAT + 1 : -1;
            q.push_back(x);
        end
    endtask

    // Monitor: checks reset quiescence, stall stability, latency and each transferred beat.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (resp_v !== 1'b0 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_quiet got v=%b ready=%b want v=0 ready=0", resp_v, cmd_ready);
            end
            prev_stall = 0; lat_done = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (resp_v !== 1'b1 || resp_hdr !== prev_hdr || resp_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold got v=%b hdr=%h data=%h want v=1 hdr=%h data=%h",
                             resp_v, resp_hdr, resp_data, prev_hdr, prev_data);
                end
            end
            if (resp_v === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat got data=%h last=%b want no beat", resp_data, resp_last);
                end else begin
                    e = q[0];
                    if (e.cyc >= 0 && !lat_done) begin
                        total++;
                        if (cyc != e.cyc) begin
                            bad++;
                            $display("FAIL first_beat_latency got cycle=%0d want cycle=%0d", cyc, e.cyc);
                        end
                        lat_done = 1;
                    end
                    if (resp_ready) begin
                        void'(q.pop_front());
                        lat_done = 0;
                        total++;
                        if (resp_hdr !== e.hdr || resp_data !== e.data || resp_last !== e.last) begin
                            bad++;
                            $display("FAIL resp_beat got hdr=%h data=%h last=%b want hdr=%h data=%h last=%b",
                                     resp_hdr, resp_data, resp_last, e.hdr, e.data, e.last);
                        end
                    end
                end
            end
            prev_stall = (resp_v === 1'b1) && !resp_ready;
            prev_hdr = resp_hdr; prev_data = resp_data;
        end
    end

    initial begin
        logic [W-1:0] d [16];
        int s, a, t;
        rst = 1'b1; cmd_v = 1'b0; cmd_last = 1'b0; cmd_hdr = '0; cmd_data = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got=%b want=1", cmd_ready);
        end
        @(posedge clk); #1;

        // 64B write of 0..7 then read back, critical-word read, byte write, non-memory message
        for (int k = 0; k < 16; k++) d[k] = W'(k);
        do_write(WR, 'h80, 6, d);
        do_read(RD, 'h80, 6, 16);
        do_read(RD, 'h98, 6, 16);
        for (int k = 0; k < 16; k++) d[k] = {8{8'hAB}};
        do_write(UC_WR, 'h83, 0, d);
        do_read(UC_RD, 'h80, 3, 16);
        for (int k = 0; k < 16; k++) d[k] = '1;
        do_write(PRE, 'h80, 3, d);
        do_read(UC_RD, 'h80, 3, 16);

        // Fill the whole array so random reads never touch uninitialised words
        for (int blk = 0; blk < ELS*(W/8)/64; blk++) begin
            for (int k = 0; k < 16; k++) d[k] = {$urandom, $urandom};
            do_write(WR, blk*64, 6, d);
        end

        rand_rdy = 1;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 16; k++) d[k] = {$urandom, $urandom};
            s = $urandom_range(0, 6);
            a = $urandom_range(0, ELS*(W/8) - 1) & ~((((1 << s) < W/8) ? (1 << s) : W/8) - 1);
            do_write($urandom_range(0, 1) ? WR : UC_WR, a, s, d);
            s = $urandom_range(0, 6);
            a = $urandom_range(0, ELS*(W/8) - 1) & ~((((1 << s) < W/8) ? (1 << s) : W/8) - 1);
            do_read($urandom_range(0, 1) ? RD : UC_RD, a, s, 16);
        end
        rand_rdy = 0;

        // Reset while beat 3 of an 8-beat read is presented; only beats 0..2 are expected
        do_read(RD, 'h80, 6, 3);
        t = 0;
        while (q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_read(UC_RD, 'h80, 3, 16);

        t = 0;
        while (q.size() != 0 && t < 2000) begin @(posedge clk); t++; end
        repeat (4) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_me_stream_mem_responder.md
Name: bp_me_stream_mem_responder

Overview:
- Synthesizable BedRock stream memory responder: the far end of the mem_cmd/mem_resp interface that cache engines (I$ UCE/CCE) initiate on.
- Accepts command header plus data beats; reads return header plus data beats; writes return a single-beat ack.
- Backed by an internal register array. Used as a small boot/scratch memory and as a synthesizable stand-in for the nonsynth memory in block-level benches.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, l2_fill_width_p, header width.
- mem_els_p, 256, array depth in l2_fill_width_p-bit words; power of 2.
- latency_p, 2, cycles from header accept to first response beat; 0 is legal.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- mem_cmd_header_i  in  mem_header_width_lp  command header (msg_type, addr, size, payload)
- mem_cmd_data_i  in  l2_fill_width_p  command data beat
- mem_cmd_v_i  in  1  command beat valid
- mem_cmd_ready_and_o  out  1  command beat ready
- mem_cmd_last_i  in  1  final command beat
- mem_resp_header_o  out  mem_header_width_lp  response header (command header echoed)
- mem_resp_data_o  out  l2_fill_width_p  response data beat
- mem_resp_v_o  out  1  response beat valid
- mem_resp_ready_and_i  in  1  response beat ready
- mem_resp_last_o  out  1  final response beat

Behaviour:
- Handshake: ready&valid on both channels. A beat transfers when v & ready_and are both high in the same cycle. Header is valid on every beat of a message. mem_resp_v_o must not drop, and header/data must not change, until the beat transfers.
- Beats per message: N = max(1, (8<<size)/l2_fill_width_p).
- Word index: (addr / (l2_fill_width_p/8)) mod mem_els_p.
- Beat order: critical-word first. Beat k uses index base + ((start_off + k) mod N), where start_off is the addr beat offset within the N-beat block. Indices wrap within the block, never across it.
- Reset: FSM enters e_ready. mem_cmd_ready_and_o=0 during reset and 1 the cycle after. mem_resp_v_o=0, mem_resp_last_o=0, beat and latency counters 0. Array contents are not reset.
- FSM states:
  - e_ready: ready_and=1. On header accept:
    - e_bedrock_mem_rd / e_bedrock_mem_uc_rd: latch header, load latency counter, go to e_wait (e_read if latency_p=0).
    - e_bedrock_mem_wr / e_bedrock_mem_uc_wr: write beat 0; go to e_write if last=0, else e_wait_ack.
    - Other msg_type: absorb beats until last, then ack with zero data (treated as a write that stores nothing).
  - e_write: ready_and=1. Each accepted beat writes index k and increments k. On last, go to e_wait_ack.
  - e_wait / e_wait_ack: ready_and=0. Counter decrements to 0, then go to e_read / e_ack.
  - e_read: mem_resp_v_o=1, data = array[index k]. k increments on transfer; last=1 at k=N-1. Last transfer returns to e_ready.
  - e_ack: single beat, v=1, last=1, data=0. Transfer returns to e_ready.
- Sub-width writes (8<<size < l2_fill_width_p): byte mask covers bytes [addr mod bytes_per_beat, +(1<<size)). Only masked bytes are written. Read returns the whole aligned word.
- No command/response overlap: ready_and=0 from header latch until the final response beat transfers (single outstanding message).
- Stall under backpressure: resp_ready_and=0 holds the current beat indefinitely.
- Reset mid-message aborts it: no response is produced, and partially written beats remain in the array.
- Read after write to the same address returns the written data (write completes before the ack).

Optional Feature:
- Macro: BP_ME_STREAM_MEM_RESPONDER_CHECK_EN.
- Defined: simulation assertions fire $error on any of:
  - cmd last asserted on the wrong beat count for size.
  - cmd last missing when the next header arrives.
  - resp v dropped or header/data changed before transfer.
  - addr index >= mem_els_p before the mod.
- Undefined: no checks; RTL behaviour identical.

Test Plan:
- Reset: hold reset_i 5 cycles -> mem_resp_v_o=0 and ready_and=0 throughout; ready_and=1 the first cycle after.
- 64B write at addr 0x80, fill width 64 (8 beats, data 0..7), then 64B read at 0x80 -> ack 1 beat with last=1; read returns 0..7 in order, last on beat 7, first beat latency_p+1 cycles after accept.
- Critical-word read at addr 0x98 after the above -> beats 3,4,5,6,7,0,1,2.
- 1B uc_wr of 0xAB at addr 0x83 over word 0x0 -> 8B uc_rd at 0x80 returns 0x00000000AB000000.
- Random resp_ready_and, 50% duty, over 100 random read/write pairs -> every read matches the scoreboard; no beat lost or duplicated; header stable while stalled.
- Assert reset_i in beat 3 of an 8-beat read -> no further resp beats; the next command is served normally.
